idma_desc64_reg_submitter: RTL



---
 rtl/idma_desc64_reg_pkg.sv | 9 +
 rtl/idma_desc64_submit_pkg.sv | 33 +++
 rtl/fifo_v3.sv | 88 ++++++++
 rtl/idma_desc64_reg_submitter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/idma_desc64_reg_pkg.sv
// Register offsets of the iDMA desc64 register wrapper, as seen by regbus initiators.
package idma_desc64_reg_pkg;

    parameter int unsigned BlockAw = 6;

    parameter logic [BlockAw-1:0] IDMA_DESC64_DESC_ADDR_OFFSET = 6'h0;
    parameter logic [BlockAw-1:0] IDMA_DESC64_STATUS_OFFSET    = 6'h8;

endpackage

// File: rtl/idma_desc64_submit_pkg.sv
// Types shared by the desc64 descriptor submitter.
// BACKOFF only exists when IDMA_DESC64_SUBMIT_RETRY_EN is defined.
package idma_desc64_submit_pkg;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Write   = 2'd1
`ifdef IDMA_DESC64_SUBMIT_RETRY_EN
        ,
        Backoff = 2'd2
`endif
    } submit_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } submit_reg_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } submit_reg_rsp_t;

    // Retry counter width; never zero so MaxRetries=0 still yields a legal vector.
    function automatic int unsigned retry_cnt_width(input int unsigned max_retries);
        return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through, interface-compatible subset of common_cells fifo_v3.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

    logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
    logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [FifoDepth];
    logic                  mem_we;

    assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    assign full_o  = (status_cnt_q == (ADDR_DEPTH + 1)'(FifoDepth));
    assign empty_o = (status_cnt_q == '0) & ~(FALL_THROUGH & push_i);

    always_comb begin
        read_ptr_d   = read_ptr_q;
        write_ptr_d  = write_ptr_q;
        status_cnt_d = status_cnt_q;
        data_o       = mem_q[read_ptr_q];
        mem_we       = 1'b0;

        if (push_i && !full_o) begin
            mem_we       = 1'b1;
            write_ptr_d  = (write_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : write_ptr_q + 1'b1;
            status_cnt_d = status_cnt_q + 1'b1;
        end

        if (pop_i && !empty_o) begin
            read_ptr_d   = (read_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : read_ptr_q + 1'b1;
            status_cnt_d = status_cnt_q - 1'b1;
        end

        if (push_i && pop_i && !full_o && !empty_o) begin
            status_cnt_d = status_cnt_q;
        end

        // Fall-through: an empty FIFO forwards the input and skips storage if popped.
        if (FALL_THROUGH && (status_cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                status_cnt_d = status_cnt_q;
                read_ptr_d   = read_ptr_q;
                write_ptr_d  = write_ptr_q;
                mem_we       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
        end else if (flush_i) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
        end else begin
            read_ptr_q   <= read_ptr_d;
            write_ptr_q  <= write_ptr_d;
            status_cnt_q <= status_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[write_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/idma_desc64_reg_submitter.sv
// Regbus initiator writing buffered descriptor addresses into the desc64 frontend.
// Define IDMA_DESC64_SUBMIT_RETRY_EN to reissue erroring writes up to MaxRetries times.
module idma_desc64_reg_submitter
    import idma_desc64_submit_pkg::*;
    import idma_desc64_reg_pkg::*;
#(
    parameter int unsigned          AddrWidth   = 32,
    parameter type                  reg_req_t   = idma_desc64_submit_pkg::submit_reg_req_t,
    parameter type                  reg_rsp_t   = idma_desc64_submit_pkg::submit_reg_rsp_t,
    parameter logic [AddrWidth-1:0] RegBaseAddr = '0,
    parameter int unsigned          FifoDepth   = 4,
    parameter int unsigned          MaxRetries  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] desc_addr_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [63:0] err_addr_o,
    output logic [31:0] submitted_cnt_o
);

    localparam logic [AddrWidth-1:0] TargetAddr =
        RegBaseAddr + AddrWidth'(IDMA_DESC64_DESC_ADDR_OFFSET);
    localparam int unsigned FifoAddrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    logic                 rst_n;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FifoAddrW-1:0] fifo_usage;
    logic [63:0]          fifo_head;
    logic                 handshake, drop, last_entry;

    submit_state_e state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [63:0]   err_addr_q, err_addr_d;

    assign rst_n = ~rst_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (64),
        .DEPTH        (FifoDepth)
    ) i_desc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_n),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (desc_addr_i),
        .push_i  (fifo_push),
        .data_o  (fifo_head),
        .pop_i   (fifo_pop)
    );

    assign desc_ready_o = ~fifo_full;
    assign fifo_push    = desc_valid_i & ~fifo_full;
    assign handshake    = (state_q == Write) & reg_rsp_i.ready;

    // usage_o wraps to 0 when full, so "exactly one left" needs the depth-1 special case.
    assign last_entry = (FifoDepth == 1) ? 1'b1 : (fifo_usage == FifoAddrW'(1));

`ifdef IDMA_DESC64_SUBMIT_RETRY_EN
    localparam int unsigned RetryW = retry_cnt_width(MaxRetries);
    logic [RetryW-1:0] retry_q, retry_d;

    assign drop = (retry_q >= RetryW'(MaxRetries));
`else
    assign drop = 1'b1;
`endif

    assign fifo_pop = handshake & (~reg_rsp_i.error | drop);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        reg_req_o  = '0;
`ifdef IDMA_DESC64_SUBMIT_RETRY_EN
        retry_d    = retry_q;
`endif

        case (state_q)
            Idle: begin
                if (!fifo_empty) begin
                    state_d = Write;
                end
            end
            Write: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.wstrb = '1;
                reg_req_o.addr  = TargetAddr;
                reg_req_o.wdata = fifo_head;
                if (handshake && !reg_rsp_i.error) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (fifo_pop) begin
                    if (reg_rsp_i.error) begin
                        err_d      = 1'b1;
                        err_addr_d = fifo_head;
                    end
                    // A concurrent push keeps the FIFO non-empty for back-to-back issue.
                    state_d = (fifo_push || !last_entry) ? Write : Idle;
`ifdef IDMA_DESC64_SUBMIT_RETRY_EN
                    retry_d = '0;
`endif
                end
`ifdef IDMA_DESC64_SUBMIT_RETRY_EN
                else if (handshake) begin
                    retry_d = retry_q + 1'b1;
                    state_d = Backoff;
                end
`endif
            end
`ifdef IDMA_DESC64_SUBMIT_RETRY_EN
            Backoff: begin
                state_d = Write;
            end
`endif
            default: begin
                state_d = Idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= Idle;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

`ifdef IDMA_DESC64_SUBMIT_RETRY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign busy_o          = (state_q != Idle) | ~fifo_empty;
    assign err_o           = err_q;
    assign err_addr_o      = err_addr_q;
    assign submitted_cnt_o = cnt_q;

endmodule
